// File: rtl/prga_pkg.sv
// Shared types and constants for the RC4 keystream/decrypt stage.
// The state encoding is private to prga; LEN_ADDR locates the length byte.
package prga_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_RD  = 4'd1,
        LEN_CAP = 4'd2,
        SI_RD   = 4'd3,
        SI_CAP  = 4'd4,
        SJ_RD   = 4'd5,
        SJ_CAP  = 4'd6,
        WR_I    = 4'd7,
        WR_J    = 4'd8,
        PAD_RD  = 4'd9,
        PAD_CAP = 4'd10
    } state_t;

    localparam int LEN_ADDR = 0;

endpackage

// File: rtl/prga.sv
// RC4 PRGA: reads a length-prefixed ciphertext, walks the permuted S memory
// left by KSA and writes the length-prefixed plaintext, 8 cycles per byte.
module prga
    import prga_pkg::*;
#(
    parameter int CT_AW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             rdy,
    output logic [7:0]       s_addr,
    input  logic [7:0]       s_rddata,
    output logic [7:0]       s_wrdata,
    output logic             s_wren,
    output logic [CT_AW-1:0] ct_addr,
    input  logic [7:0]       ct_rddata,
    output logic [CT_AW-1:0] pt_addr,
    output logic [7:0]       pt_wrdata,
    output logic             pt_wren
);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_i;
    logic [7:0] r_j;
    logic [7:0] r_k;
    logic [7:0] r_len;
    logic [7:0] r_si;
    logic [7:0] r_sj;
    logic [7:0] w_padIdx;

    assign w_padIdx = r_si + r_sj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (en) w_next = LEN_RD;
            LEN_RD:  w_next = LEN_CAP;
            LEN_CAP: w_next = (ct_rddata == 8'd0) ? IDLE : SI_RD;
            SI_RD:   w_next = SI_CAP;
            SI_CAP:  w_next = SJ_RD;
            SJ_RD:   w_next = SJ_CAP;
            SJ_CAP:  w_next = WR_I;
            WR_I:    w_next = WR_J;
            WR_J:    w_next = PAD_RD;
            PAD_RD:  w_next = PAD_CAP;
            PAD_CAP: w_next = (r_k == r_len) ? IDLE : SI_RD;
            default: w_next = IDLE;
        endcase
    end

    // Index/byte registers; i and j restart from zero on every accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i   <= 8'd0;
            r_j   <= 8'd0;
            r_k   <= 8'd0;
            r_len <= 8'd0;
            r_si  <= 8'd0;
            r_sj  <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_i <= 8'd0;
                        r_j <= 8'd0;
                    end
                end
                LEN_CAP: begin
                    r_len <= ct_rddata;
                    if (ct_rddata != 8'd0) begin
                        r_k <= 8'd1;
                        r_i <= 8'd1;
                    end
                end
                SI_CAP: begin
                    r_si <= s_rddata;
                    r_j  <= r_j + s_rddata;
                end
                SJ_CAP: r_sj <= s_rddata;
                PAD_CAP: begin
                    if (r_k != r_len) begin
                        r_k <= r_k + 8'd1;
                        r_i <= r_i + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from state alone, so an async reset silences writes at once.
    always_comb begin
        rdy       = 1'b0;
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;
        case (r_state)
            IDLE:    rdy = 1'b1;
            LEN_RD:  ct_addr = CT_AW'(LEN_ADDR);
            LEN_CAP: begin
                pt_addr   = CT_AW'(LEN_ADDR);
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
            end
            SI_RD:   s_addr = r_i;
            SJ_RD:   s_addr = r_j;
            WR_I: begin
                s_addr   = r_i;
                s_wrdata = r_sj;
                s_wren   = 1'b1;
            end
            WR_J: begin
                s_addr   = r_j;
                s_wrdata = r_si;
                s_wren   = 1'b1;
            end
            PAD_RD: begin
                s_addr  = w_padIdx;
                ct_addr = CT_AW'(r_k);
            end
            PAD_CAP: begin
                pt_addr   = CT_AW'(r_k);
                pt_wrdata = s_rddata ^ ct_rddata;
                pt_wren   = 1'b1;
            end
            default: rdy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_prga.sv
// Self-checking bench for prga: memory models, directed table, corner
// sequences and randomized messages against a plain RC4 reference model.
module tb_prga;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       rdy;
    logic [7:0] s_addr;
    logic [7:0] s_rddata;
    logic [7:0] s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr;
    logic [7:0] ct_rddata;
    logic [7:0] pt_addr;
    logic [7:0] pt_wrdata;
    logic       pt_wren;

    logic [7:0] sMem [256];
    logic [7:0] ctMem [256];
    logic [7:0] ptMem [256];
    logic [7:0] modelS [256];
    logic [7:0] modelPt [256];
    int         sWrites;
    int         ptWrites;
    int         checkCount;
    int         failCount;

    prga #(.CT_AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
        .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .ct_addr(ct_addr), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous-read memories; read data lags the address by one cycle.
    always @(posedge clk) begin
        s_rddata  <= sMem[s_addr];
        ct_rddata <= ctMem[ct_addr];
        if (s_wren) begin
            sMem[s_addr] = s_wrdata;
            sWrites++;
        end
        if (pt_wren) begin
            ptMem[pt_addr] = pt_wrdata;
            ptWrites++;
        end
    end

    typedef struct {
        logic [7:0] ct0, ct1, ct2;
        logic [7:0] pt0, pt1, pt2;
        int         lowCycles;
        int         ptWr;
        int         sWr;
        logic [7:0] s2, s3;
    } vec_t;

    vec_t vecs [3];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic resetDut();
        en    = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic loadIdentity();
        for (int x = 0; x < 256; x++) sMem[x] = 8'(x);
    endtask

    task automatic loadRandomPerm();
        logic [7:0] t;
        int         r;
        loadIdentity();
        for (int x = 255; x > 0; x--) begin
            r = $urandom_range(x, 0);
            t = sMem[x]; sMem[x] = sMem[r]; sMem[r] = t;
        end
    endtask

    // Textbook RC4 key schedule for the 3-byte key 00 03 3C.
    task automatic loadKsa();
        logic [7:0] key [3];
        logic [7:0] t;
        logic [7:0] j;
        key[0] = 8'h00; key[1] = 8'h03; key[2] = 8'h3C;
        loadIdentity();
        j = 8'd0;
        for (int x = 0; x < 256; x++) begin
            j = j + sMem[x] + key[x % 3];
            t = sMem[x]; sMem[x] = sMem[j]; sMem[j] = t;
        end
    endtask

    // Textbook RC4 PRGA over a copy of the current S, decrypting ctMem.
    task automatic refRc4(input int len);
        logic [7:0] i, j, t;
        for (int x = 0; x < 256; x++) modelS[x] = sMem[x];
        modelPt[0] = 8'(len);
        i = 8'd0; j = 8'd0;
        for (int n = 1; n <= len; n++) begin
            i = i + 8'd1;
            j = j + modelS[i];
            t = modelS[i]; modelS[i] = modelS[j]; modelS[j] = t;
            modelPt[n] = ctMem[n] ^ modelS[8'(modelS[i] + modelS[j])];
        end
    endtask

    task automatic clearPt();
        for (int x = 0; x < 256; x++) ptMem[x] = 8'hAA;
    endtask

    task automatic countLow(output int low);
        low = 0;
        while (rdy == 1'b0 && low < 3000) begin
            low++;
            @(negedge clk);
        end
        if (low >= 3000) checkOutput("rdy_timeout", low, 0);
    endtask

    task automatic applyStimulus(output int low);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        countLow(low);
    endtask

    task automatic checkAgainstModel(input string tag, input int len, input int low);
        int bad;
        checkOutput({tag, "_low"}, low, 2 + 8 * len);
        bad = 0;
        for (int n = 0; n <= len; n++) if (ptMem[n] !== modelPt[n]) bad++;
        checkOutput({tag, "_pt_mismatches"}, bad, 0);
        bad = 0;
        for (int x = 0; x < 256; x++) if (sMem[x] !== modelS[x]) bad++;
        checkOutput({tag, "_s_mismatches"}, bad, 0);
    endtask

    initial begin
        int low, low2, sw, pw, bad, guard, len;
        checkCount = 0;
        failCount  = 0;
        sWrites    = 0;
        ptWrites   = 0;
        for (int x = 0; x < 256; x++) ctMem[x] = 8'h00;
        loadIdentity();

        vecs[0] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h02, 8'hAA, 10, 2, 2, 8'h02, 8'h03};
        vecs[1] = '{8'h02, 8'h00, 8'hFF, 8'h02, 8'h02, 8'hFA, 18, 3, 4, 8'h03, 8'h02};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hAA, 2,  1, 0, 8'h02, 8'h03};

        resetDut();
        checkOutput("reset_rdy", rdy, 1);
        checkOutput("reset_s_wren", s_wren, 0);
        checkOutput("reset_pt_wren", pt_wren, 0);
        checkOutput("reset_addrs", {s_addr, ct_addr, pt_addr}, 0);
        checkOutput("reset_wrdata", {s_wrdata, pt_wrdata}, 0);

        for (int v = 0; v < 3; v++) begin
            resetDut();
            loadIdentity();
            clearPt();
            ctMem[0] = vecs[v].ct0; ctMem[1] = vecs[v].ct1; ctMem[2] = vecs[v].ct2;
            sw = sWrites; pw = ptWrites;
            applyStimulus(low);
            checkOutput($sformatf("vec%0d_low", v), low, vecs[v].lowCycles);
            checkOutput($sformatf("vec%0d_pt0", v), ptMem[0], vecs[v].pt0);
            checkOutput($sformatf("vec%0d_pt1", v), ptMem[1], vecs[v].pt1);
            checkOutput($sformatf("vec%0d_pt2", v), ptMem[2], vecs[v].pt2);
            checkOutput($sformatf("vec%0d_ptwrites", v), ptWrites - pw, vecs[v].ptWr);
            checkOutput($sformatf("vec%0d_swrites", v), sWrites - sw, vecs[v].sWr);
            bad = 0;
            for (int x = 0; x < 256; x++) begin
                if (x == 2 && sMem[x] !== vecs[v].s2) bad++;
                else if (x == 3 && sMem[x] !== vecs[v].s3) bad++;
                else if (x != 2 && x != 3 && sMem[x] !== 8'(x)) bad++;
            end
            checkOutput($sformatf("vec%0d_s_mismatches", v), bad, 0);
        end

        // en held high: the run must not restart midway, and the back-to-back rerun starts from i=j=0.
        resetDut();
        loadIdentity();
        clearPt();
        ctMem[0] = 8'h02; ctMem[1] = 8'h00; ctMem[2] = 8'hFF;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        countLow(low);
        checkOutput("holden_low1", low, 18);
        checkOutput("holden_pt2_run1", ptMem[2], 8'hFA);
        loadIdentity();
        clearPt();
        @(negedge clk);
        countLow(low2);
        en = 1'b0;
        checkOutput("holden_low2", low2, 18);
        checkOutput("holden_pt1_run2", ptMem[1], 8'h02);
        checkOutput("holden_pt2_run2", ptMem[2], 8'hFA);

        // Reset asserted during WR_J of the first byte.
        resetDut();
        loadIdentity();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        guard = 0;
        while (s_wren == 1'b0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        checkOutput("midrst_wrj_wren", s_wren, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_s_wren", s_wren, 0);
        checkOutput("midrst_rdy", rdy, 1);
        sw = sWrites; pw = ptWrites;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("midrst_no_swrites", sWrites - sw, 0);
        checkOutput("midrst_no_ptwrites", ptWrites - pw, 0);
        checkOutput("midrst_idle_rdy", rdy, 1);

        // Short random messages over random permutations.
        for (int r = 0; r < 4; r++) begin
            resetDut();
            loadRandomPerm();
            clearPt();
            len = $urandom_range(12, 1);
            ctMem[0] = 8'(len);
            for (int n = 1; n <= len; n++) ctMem[n] = 8'($urandom);
            refRc4(len);
            applyStimulus(low);
            checkAgainstModel($sformatf("rand%0d", r), len, low);
        end

        // Full-length message over the KSA output for key 00033C.
        resetDut();
        loadKsa();
        clearPt();
        ctMem[0] = 8'hFF;
        for (int n = 1; n < 256; n++) ctMem[n] = 8'($urandom);
        refRc4(255);
        applyStimulus(low);
        checkAgainstModel("ksa255", 255, low);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/prga.md
Name: prga

Overview:
- RC4 keystream-generation and decrypt stage; sits directly downstream of the KSA stage and consumes the permuted S memory it leaves behind.
- On start, reads a length-prefixed ciphertext, runs the RC4 PRGA over S, and writes a length-prefixed plaintext.
- Shares S memory with init/ksa through the top-level mux; ciphertext ROM and plaintext RAM are external.
- All memories are single-port synchronous-read.

Parameters:
- CT_AW, 8, address width of ciphertext and plaintext memories; the length byte limits messages to 255 bytes.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  start request; honoured only while rdy=1
- rdy  out  1  idle/ready
- s_addr  out  8  S memory address
- s_rddata  in  8  S memory read data
- s_wrdata  out  8  S memory write data
- s_wren  out  1  S memory write enable
- ct_addr  out  CT_AW  ciphertext address
- ct_rddata  in  8  ciphertext read data
- pt_addr  out  CT_AW  plaintext address
- pt_wrdata  out  8  plaintext write data
- pt_wren  out  1  plaintext write enable

Behaviour:
- Memory timing: an address driven during cycle t yields rddata during cycle t+1. A write commits at the end of the cycle in which wren=1.
- Reset (async, rst_n=0): state=IDLE; i=j=k=len=si=sj=0; rdy=1; all addresses, wrdata and wren are 0.
- IDLE: rdy=1, no memory activity.
  - en=1 at a clock edge moves to LEN_RD; rdy=0 from the next cycle.
  - en while rdy=0 is ignored.
  - Internal i and j are cleared on every start.
- LEN_RD: ct_addr=0.
- LEN_CAP: len<=ct_rddata; pt_addr=0, pt_wrdata=ct_rddata, pt_wren=1.
  - If ct_rddata==0, go to IDLE.
  - Otherwise k<=1, i<=1, go to SI_RD.
- SI_RD: s_addr=i.
- SI_CAP: si<=s_rddata; j<=j+s_rddata (mod 256).
- SJ_RD: s_addr=j.
- SJ_CAP: sj<=s_rddata.
- WR_I: s_addr=i, s_wrdata=sj, s_wren=1.
- WR_J: s_addr=j, s_wrdata=si, s_wren=1.
  - When i==j, both writes store the same value and S is unchanged.
- PAD_RD: s_addr=(si+sj) mod 256, ct_addr=k. The pad read follows both swap writes, so it sees post-swap S.
- PAD_CAP: pt_addr=k, pt_wrdata=s_rddata^ct_rddata, pt_wren=1.
  - If k==len, go to IDLE.
  - Otherwise k<=k+1, i<=i+1 (mod 256), go to SI_RD.
- Arithmetic: all S index math is 8-bit wraparound.
- Throughput and latency: 8 cycles per byte. rdy is low for exactly 2+8*len cycles.
- In every state except WR_I, WR_J, LEN_CAP and PAD_CAP, both wren outputs are 0. At most one wren is high in any cycle.
- Reset mid-operation:
  - rst_n low takes immediate effect: wren outputs drop to 0 and rdy goes to 1 asynchronously.
  - S contents are left partially permuted. The top level must rerun init and ksa before the next start.
- Undefined state encodings fall to IDLE.

Decomposition:
- Package prga_pkg: state enum (IDLE, LEN_RD, LEN_CAP, SI_RD, SI_CAP, SJ_RD, SJ_CAP, WR_I, WR_J, PAD_RD, PAD_CAP) and constant LEN_ADDR=0.
- Single module, no sub-module. The datapath (i, j, k, si, sj, len registers plus an 8-bit adder and XOR) is small enough to keep inline with the FSM.

Test Plan:
- Identity S (S[x]=x), ct={01,00}, pulse en -> pt[0]=01, pt[1]=02; exercises the i==j=1 self-swap; S unchanged; rdy low exactly 10 cycles.
- Identity S, ct={02,00,FF} -> pt={02,02,FA}; S[2]=03, S[3]=02, all other S unchanged; rdy low 18 cycles.
- ct={00} -> pt[0]=00 written; no S or pt[1] writes; rdy low 2 cycles.
- Assert en throughout a 2-byte run -> no restart mid-run; second start begins with i=j=0; rerun on reset S gives identical pt.
- rst_n low during WR_J of byte 1 -> s_wren=0 and rdy=1 in the same cycle; after release with en=0, no memory writes occur.
- Random 255-byte message against a software RC4 model over KSA output for key 0x00033C -> pt matches byte-for-byte; rdy low 2042 cycles.
